// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer.
// Contents:
//   instr_type_e - instruction-format codes, same encoding as the core's
//                  immediate decoder (000..100; 101..111 are illegal).
//   err_e        - result status codes carried with every packed word.
//   *_LSB/_POS   - bit positions of the immediate fields in the instruction.
//   fitsSigned   - representability helper for sign-extended immediates.
package imm_pack_pkg;

  typedef enum logic [2:0] {
    TYPE_I = 3'b000,
    TYPE_S = 3'b001,
    TYPE_B = 3'b010,
    TYPE_U = 3'b011,
    TYPE_J = 3'b100
  } instr_type_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  // Instruction bit positions of the scattered immediate fields.
  localparam int I_IMM_LSB  = 20;
  localparam int S_HI_LSB   = 25;
  localparam int S_LO_LSB   = 7;
  localparam int B_SIGN_POS = 31;
  localparam int B_HI_LSB   = 25;
  localparam int B_LO_LSB   = 8;
  localparam int B_B11_POS  = 7;
  localparam int U_IMM_LSB  = 12;
  localparam int J_SIGN_POS = 31;
  localparam int J_LO_LSB   = 21;
  localparam int J_B11_POS  = 20;
  localparam int J_MID_LSB  = 12;

  // Lowest immediate bit of the run that must be pure sign extension.
  localparam int unsigned I_RANGE_LSB = 11;
  localparam int unsigned B_RANGE_LSB = 12;
  localparam int unsigned J_RANGE_LSB = 20;

  // True when value[31:lsb] are all equal, i.e. the value survives
  // truncation to lsb+1 bits followed by sign extension.
  function automatic logic fitsSigned(input logic [31:0] value, input int unsigned lsb);
    logic [31:0] shifted;
    shifted = 32'($signed(value) >>> lsb);
    return (shifted == '0) || (shifted == '1);
  endfunction

endpackage

// File: rtl/imm_pack_merge.sv
// Combinational check + merge for one instruction word.
// Ports:
//   type_i  [2:0]  instruction format code
//   base_i  [31:0] instruction whose non-immediate bits are kept
//   imm_i   [31:0] immediate value (byte offset for B/J)
//   instr_o [31:0] base_i with the immediate scattered into its fields
//   err_o   [1:0]  status: ok, range, misaligned, illegal type
module imm_pack_merge
  import imm_pack_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [31:0] base_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic [1:0]  err_o
);

  // Scatter the immediate and classify it. The truncated merge is produced
  // even when the immediate is not representable, so the downstream loader
  // always sees a well-formed word next to the error code. Misalignment is
  // tested before range so it wins when both apply. A U immediate with
  // non-zero low bits cannot be encoded at all and is reported as range.
  always_comb begin
    instr_o = base_i;
    err_o   = ERR_OK;
    case (type_i)
      TYPE_I: begin
        instr_o[I_IMM_LSB +: 12] = imm_i[11:0];
        if (!fitsSigned(imm_i, I_RANGE_LSB)) err_o = ERR_RANGE;
      end
      TYPE_S: begin
        instr_o[S_HI_LSB +: 7] = imm_i[11:5];
        instr_o[S_LO_LSB +: 5] = imm_i[4:0];
        if (!fitsSigned(imm_i, I_RANGE_LSB)) err_o = ERR_RANGE;
      end
      TYPE_B: begin
        instr_o[B_SIGN_POS]    = imm_i[12];
        instr_o[B_HI_LSB +: 6] = imm_i[10:5];
        instr_o[B_LO_LSB +: 4] = imm_i[4:1];
        instr_o[B_B11_POS]     = imm_i[11];
        if (imm_i[0])                             err_o = ERR_MISALIGN;
        else if (!fitsSigned(imm_i, B_RANGE_LSB)) err_o = ERR_RANGE;
      end
      TYPE_U: begin
        instr_o[U_IMM_LSB +: 20] = imm_i[31:12];
        if (imm_i[11:0] != 12'h000) err_o = ERR_RANGE;
      end
      TYPE_J: begin
        instr_o[J_SIGN_POS]     = imm_i[20];
        instr_o[J_LO_LSB +: 10] = imm_i[10:1];
        instr_o[J_B11_POS]      = imm_i[11];
        instr_o[J_MID_LSB +: 8] = imm_i[19:12];
        if (imm_i[0])                             err_o = ERR_MISALIGN;
        else if (!fitsSigned(imm_i, J_RANGE_LSB)) err_o = ERR_RANGE;
      end
      default: begin
        err_o = ERR_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/imm_pack_stream.sv
// Streaming immediate packer: two-stage valid/ready pipeline around
// imm_pack_merge, with saturating counters of delivered ok/error words.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous drop of both pipeline stages
//   in_valid/in_ready    input handshake; in_type, in_base, in_imm payload
//   out_valid/out_ready  output handshake; out_instr, out_err payload
//   cnt_ok, cnt_err      saturating counts of delivered ok / error words
module imm_pack_stream
  import imm_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  logic             aValid_q, aValid_d;
  logic [31:0]      aInstr_q, aInstr_d;
  logic [1:0]       aErr_q, aErr_d;
  logic             bValid_q, bValid_d;
  logic [31:0]      bInstr_q, bInstr_d;
  logic [1:0]       bErr_q, bErr_d;
  logic [CNT_W-1:0] cntOk_q, cntOk_d;
  logic [CNT_W-1:0] cntErr_q, cntErr_d;

  logic        bLoad;
  logic        aLoad;
  logic        outFire;
  logic [31:0] mergeInstr;
  logic [1:0]  mergeErr;

  imm_pack_merge u_merge (
    .type_i  (in_type),
    .base_i  (in_base),
    .imm_i   (in_imm),
    .instr_o (mergeInstr),
    .err_o   (mergeErr)
  );

  // Each stage may load when it is empty or the stage after it is moving,
  // so a full pipeline still advances every cycle while out_ready is high.
  // A handshake in a flush cycle is dropped and not counted.
  assign bLoad   = !bValid_q || out_ready;
  assign aLoad   = !aValid_q || bLoad;
  assign outFire = bValid_q && out_ready && !flush;

  assign in_ready  = aLoad;
  assign out_valid = bValid_q;
  assign out_instr = bInstr_q;
  assign out_err   = bErr_q;
  assign cnt_ok    = cntOk_q;
  assign cnt_err   = cntErr_q;

  // Next-state for both stages and the counters. Payload registers only
  // load when a valid word arrives, which keeps them stable while stalled.
  always_comb begin
    aValid_d = aValid_q;
    aInstr_d = aInstr_q;
    aErr_d   = aErr_q;
    bValid_d = bValid_q;
    bInstr_d = bInstr_q;
    bErr_d   = bErr_q;
    cntOk_d  = cntOk_q;
    cntErr_d = cntErr_q;

    if (flush) begin
      aValid_d = 1'b0;
      bValid_d = 1'b0;
    end else begin
      if (bLoad) begin
        bValid_d = aValid_q;
        if (aValid_q) begin
          bInstr_d = aInstr_q;
          bErr_d   = aErr_q;
        end
      end
      if (aLoad) begin
        aValid_d = in_valid;
        if (in_valid) begin
          aInstr_d = mergeInstr;
          aErr_d   = mergeErr;
        end
      end
    end

    if (outFire) begin
      if (bErr_q == ERR_OK) begin
        if (cntOk_q != '1) cntOk_d = cntOk_q + CNT_W'(1);
      end else begin
        if (cntErr_q != '1) cntErr_d = cntErr_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aValid_q <= 1'b0;
      aInstr_q <= '0;
      aErr_q   <= ERR_OK;
      bValid_q <= 1'b0;
      bInstr_q <= '0;
      bErr_q   <= ERR_OK;
      cntOk_q  <= '0;
      cntErr_q <= '0;
    end else begin
      aValid_q <= aValid_d;
      aInstr_q <= aInstr_d;
      aErr_q   <= aErr_d;
      bValid_q <= bValid_d;
      bInstr_q <= bInstr_d;
      bErr_q   <= bErr_d;
      cntOk_q  <= cntOk_d;
      cntErr_q <= cntErr_d;
    end
  end

endmodule

// File: tb/tb_imm_pack_stream.sv
// Self-checking bench for imm_pack_stream: directed cases, backpressure,
// random round-trip through an immediate decoder, reset and flush mid-stream.
module tb_imm_pack_stream;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_type = 3'd0;
  logic [31:0]      in_base = 32'd0;
  logic [31:0]      in_imm = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  imm_pack_stream #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [2:0]  kind;
    logic [31:0] imm;
  } exp_t;

  exp_t             expQ[$];
  int               checks = 0;
  int               errors = 0;
  int               popCount = 0;
  logic [CNT_W-1:0] expOk = '0;
  logic [CNT_W-1:0] expErr = '0;
  logic             randReady = 1'b0;
  logic             prevStall = 1'b0;
  logic [31:0]      prevInstr = '0;
  logic [1:0]       prevErr = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Which immediate bit lands on instruction bit pos (-1: kept from base).
  function automatic int immSrcBit(input logic [2:0] kind, input int pos);
    case (kind)
      3'd0: return (pos >= 20) ? pos - 20 : -1;
      3'd1: begin
        if (pos >= 25) return pos - 20;
        if (pos >= 7 && pos <= 11) return pos - 7;
        return -1;
      end
      3'd2: begin
        if (pos == 31) return 12;
        if (pos >= 25) return pos - 20;
        if (pos >= 8 && pos <= 11) return pos - 7;
        if (pos == 7) return 11;
        return -1;
      end
      3'd3: return (pos >= 12) ? pos : -1;
      3'd4: begin
        if (pos == 31) return 20;
        if (pos >= 21) return pos - 20;
        if (pos == 20) return 11;
        if (pos >= 12) return pos;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] refPack(input logic [2:0] kind, input logic [31:0] base, input logic [31:0] imm);
    logic [31:0] r;
    int src;
    r = base;
    for (int pos = 0; pos < 32; pos++) begin
      src = immSrcBit(kind, pos);
      if (src >= 0) r[pos] = imm[src];
    end
    return r;
  endfunction

  function automatic logic [1:0] refErr(input logic [2:0] kind, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (kind)
      3'd0, 3'd1: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
      3'd2: begin
        if (imm[0]) return 2'd2;
        return (s < -4096 || s > 4095) ? 2'd1 : 2'd0;
      end
      3'd3: return ((imm % 32'd4096) != 32'd0) ? 2'd1 : 2'd0;
      3'd4: begin
        if (imm[0]) return 2'd2;
        return (s < -1048576 || s > 1048575) ? 2'd1 : 2'd0;
      end
      default: return 2'd3;
    endcase
  endfunction

  // The core's immediate decoder.
  function automatic logic [31:0] decodeImm(input logic [2:0] kind, input logic [31:0] instr);
    case (kind)
      3'd0: return {{20{instr[31]}}, instr[31:20]};
      3'd1: return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2: return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3: return {instr[31:12], 12'h000};
      3'd4: return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return instr;
    endcase
  endfunction

  task automatic genLegal(output logic [2:0] kind, output logic [31:0] imm);
    int v;
    kind = 3'($urandom_range(0, 4));
    case (kind)
      3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd3:       v = int'($urandom & 32'hFFFF_F000);
      default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
    endcase
    imm = v;
  endtask

  // Scoreboard: records accepted words, checks delivered words in order,
  // tracks the expected counters and verifies stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expQ.delete();
      expOk = '0;
      expErr = '0;
      prevStall = 1'b0;
    end else begin
      checkOutput("cnt_ok", 32'(cnt_ok), 32'(expOk));
      checkOutput("cnt_err", 32'(cnt_err), 32'(expErr));
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_instr", out_instr, prevInstr);
        checkOutput("stall_err", 32'(out_err), 32'(prevErr));
      end
      prevStall = out_valid && !out_ready && !flush;
      prevInstr = out_instr;
      prevErr   = out_err;
      if (flush) begin
        expQ.delete();
      end else begin
        if (out_valid && out_ready) begin
          popCount++;
          if (expQ.size() == 0) begin
            checkOutput("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_instr", out_instr, e.instr);
            checkOutput("sb_err", 32'(out_err), 32'(e.err));
            if (e.err == 2'd0) checkOutput("roundtrip", decodeImm(e.kind, out_instr), e.imm);
            if (e.err == 2'd0) begin
              if (expOk != CNT_MAX) expOk++;
            end else begin
              if (expErr != CNT_MAX) expErr++;
            end
          end
        end
        if (in_valid && in_ready) begin
          e.kind  = in_type;
          e.imm   = in_imm;
          e.instr = refPack(in_type, in_base, in_imm);
          e.err   = refErr(in_type, in_imm);
          expQ.push_back(e);
        end
      end
    end
  end

  // Offer one word and hold it until accepted. Starts and ends just after
  // a rising edge.
  task automatic applyStimulus(input logic [2:0] kind, input logic [31:0] base, input logic [31:0] imm);
    logic acc;
    int n;
    in_type  = kind;
    in_base  = base;
    in_imm   = imm;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic expectNext(input string tag, input logic [31:0] instr, input logic [1:0] err);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_instr"}, out_instr, instr);
    checkOutput({tag, "_err"}, 32'(out_err), 32'(err));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    randReady = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((expQ.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [2:0]  kind;
    logic [31:0] imm;
    logic [2:0]  bpKind[3];
    logic [31:0] bpImm[3];
    logic [31:0] bpBase[3];
    logic        acc;
    int          idx;
    int          popsBefore;

    // Reset values while held in reset.
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    checkOutput("rst_cnt_err", 32'(cnt_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed cases, including the two-cycle latency.
    applyStimulus(3'b000, 32'h0000_0093, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("i_instr", out_instr, 32'hFFF0_0093);
    checkOutput("i_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("cnt_ok_first", 32'(cnt_ok), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(3'b010, 32'h0000_0063, 32'h0000_0010);
    expectNext("b_ok", 32'h0000_0863, 2'b00);
    applyStimulus(3'b010, 32'h0000_0063, 32'h0000_0011);
    expectNext("b_misalign", 32'h0000_0863, 2'b10);
    applyStimulus(3'b101, 32'h1234_5678, 32'hDEAD_BEEF);
    expectNext("illegal", 32'h1234_5678, 2'b11);
    applyStimulus(3'b000, 32'h0000_0093, 32'h0000_0800);
    expectNext("i_range", 32'h8000_0093, 2'b01);
    @(negedge clk);
    checkOutput("dir_cnt_ok", 32'(cnt_ok), 32'd2);
    checkOutput("dir_cnt_err", 32'(cnt_err), 32'd3);
    @(posedge clk);
    #1;

    // Backpressure: three words offered while the output is blocked.
    for (int i = 0; i < 3; i++) begin
      genLegal(bpKind[i], bpImm[i]);
      bpBase[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        in_type  = bpKind[idx];
        in_base  = bpBase[idx];
        in_imm   = bpImm[idx];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", 32'(idx), 32'd2);
    @(negedge clk);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    popsBefore = popCount;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    while (idx < 3) begin
      applyStimulus(bpKind[idx], bpBase[idx], bpImm[idx]);
      idx++;
    end
    waitDrain("bp");
    checkOutput("bp_pops", 32'(popCount - popsBefore), 32'd3);

    // Random legal words with random backpressure: round-trip must hold.
    randReady = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      genLegal(kind, imm);
      applyStimulus(kind, $urandom, imm);
      if ($urandom_range(0, 7) == 0) idleCycles(1);
    end
    // Unconstrained words exercise every error path.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'(int'($urandom_range(0, 16383)) - 8192);
        default: genLegal(kind, imm);
      endcase
      applyStimulus(3'($urandom_range(0, 7)), $urandom, imm);
    end
    waitDrain("random");

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      genLegal(kind, imm);
      applyStimulus(kind, $urandom, imm);
    end
    checkOutput("rstmid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rstmid_out_instr", out_instr, 32'd0);
    checkOutput("rstmid_out_err", 32'(out_err), 32'd0);
    checkOutput("rstmid_cnt_ok", 32'(cnt_ok), 32'd0);
    checkOutput("rstmid_cnt_err", 32'(cnt_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rstmid_post_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Flush with both stages full, a pending output pop and a new input.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      genLegal(kind, imm);
      applyStimulus(kind, $urandom, imm);
    end
    checkOutput("flush_pre_valid", 32'(out_valid), 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_type   = 3'b000;
    in_base   = 32'h0000_0013;
    in_imm    = 32'h0000_0005;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_cnt_ok", 32'(cnt_ok), 32'd0);
    checkOutput("flush_cnt_err", 32'(cnt_err), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("flush_no_ghost", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'b001, 32'h0000_2023, 32'hFFFF_F800);
    expectNext("post_flush", 32'h8000_2023, 2'b00);
    waitDrain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_pack_stream.md
Name: imm_pack_stream

Overview:
- Streaming immediate packer: the inverse of the core's immediate decoder.
- Takes a base instruction word, a 32-bit signed/unsigned immediate and an instruction-format code, and produces the instruction with the immediate scattered into the format-specific bit fields.
- Checks representability of the immediate and flags errors.
- Sits in front of the instruction-memory loader and trampoline/patch generator.
- Valid/ready on both sides, 2-stage pipeline, output-handshake statistics counters.

Parameters:
- CNT_W, 16, width of saturating ok/error counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops both pipeline stages.
- in_valid  in  1  input word offered.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_type  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
- in_base  in  32  opcode/rd/rs/funct bits; immediate-field bits are overwritten.
- in_imm  in  32  immediate value (byte offset for B/J).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  packed instruction.
- out_err  out  2  00 ok, 01 range, 10 misaligned, 11 illegal type.
- cnt_ok  out  CNT_W  saturating count of delivered err=00 words.
- cnt_err  out  CNT_W  saturating count of delivered err!=00 words.

Behaviour:
- Reset (async assert, sync-safe release): both stage valids = 0, out_valid = 0, out_instr = 0, out_err = 00, cnt_ok = 0, cnt_err = 0; in_ready = 1 the first cycle after release.
- Merge (unlisted bits from in_base):
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - B: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - U: [31:12] = imm[31:12].
  - J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12].
  - Illegal type: out_instr = in_base unchanged.
- Checks:
  - I/S: imm[31:11] all equal.
  - B: imm[0] = 0 and imm[31:12] all equal.
  - U: imm[11:0] = 0.
  - J: imm[0] = 0 and imm[31:20] all equal.
  - Priority: illegal type (11) > misaligned (10) > range (01).
  - On any error the truncated merge is still emitted.
- Pipeline:
  - Stage A registers check + merge result.
  - Stage B is the output register.
  - B loads when !B_valid || out_ready.
  - A loads when !A_valid || B loads.
  - in_ready = !A_valid || B loads (combinational from out_ready; no in_valid dependence).
- Latency: accept in cycle N -> out_valid in cycle N+2 with no stall. Throughput 1/cycle.
- Backpressure:
  - With out_ready low, up to 2 words are held, then in_ready = 0.
  - Order is preserved; out_instr/out_err are stable while out_valid && !out_ready.
- Flush:
  - Clears A_valid and B_valid next cycle.
  - Input handshake in the flush cycle is discarded.
  - Counters are unaffected; flush does not count a pending output handshake.
- Counters:
  - Increment on out_valid && out_ready (ok or err by out_err).
  - Saturate at all-ones, no wrap.
- Simultaneous output pop and input push with both stages full: all advance, no bubble.

Decomposition:
- Package imm_pack_pkg holds:
  - instr-type enum (shared with the decoder's encoding 000-100).
  - Error-code enum.
  - Field-position constants.
- One combinational sub-module, imm_pack_merge (check + merge), feeding stage A. The top keeps the pipeline, handshake and counters.

Test Plan:
- I: base 0x00000093, imm 0xFFFFFFFF, type 000 -> out_instr 0xFFF00093, err 00, out_valid 2 cycles after accept, cnt_ok = 1.
- B: base 0x00000063, imm 0x00000010 -> 0x00000863 err 00; imm 0x00000011 -> err 10; type 101 base 0x12345678 -> out 0x12345678 err 11.
- I range: base 0x00000093, imm 0x00000800 -> out 0x80000093, err 01, cnt_err increments.
- Backpressure: out_ready = 0 for 5 cycles while 3 words offered -> in_ready drops after 2 accepts; on release, all 3 emerge in order, none lost or duplicated.
- Round-trip: 1000 random legal (type, imm) -> feeding out_instr through the core's immediate decoder returns in_imm exactly; err always 00.
- Flush/reset mid-stream with both stages full:
  - Flush -> out_valid = 0 next cycle, counters unchanged.
  - rst_n low -> all outputs at reset values immediately, without a clock edge.
